// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch slice
package fetch_pkg;
  typedef logic [29:0] pc_word_t;
  typedef logic [31:0] inst_t;
  typedef struct packed {
    inst_t    inst;
    pc_word_t pc;
  } fetch_entry_t;
  localparam pc_word_t DEFAULT_RESET_PC = 30'h0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry response buffer of fetched words with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   din,
  output fetch_entry_t                   dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // Zero the head while empty so outputs read as zero after reset or flush
  assign dout  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer; one ROM read per cycle, one in flight, buffered
// responses handed to decode over valid/ready, redirects flush stale fetches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter pc_word_t RESET_PC = DEFAULT_RESET_PC,
  parameter int       DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [29:0] out_pc
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  pc_word_t      fpc, rpc;
  logic          inflight, issue, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fetch_entry_t  rsp, head;
  assign pop      = out_valid && out_ready;
  assign push     = inflight && !redirect_valid;
  assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
  // Reserve a FIFO slot for every read before issuing it, so responses never overflow
  assign issue    = !redirect_valid && (occ < DEPTH_W || (occ == DEPTH_W && pop));
  assign rsp      = '{inst: imem_inst, pc: rpc};
  assign imem_pc  = fpc;
  assign out_valid = !empty;
  assign out_inst = head.inst;
  assign out_pc   = head.pc;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (rsp),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fpc      <= RESET_PC;
      rpc      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      fpc      <= redirect_valid ? redirect_pc : issue ? fpc + 30'd1 : fpc;
      if (issue) rpc <= fpc;
    end
  assert property (@(posedge clk) disable iff (!rst_n) occ <= DEPTH_W);
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and mixed stimulus against an in-order delivery model
module tb_fetch_ctrl;
  localparam logic [29:0] RESET_PC = 30'h0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [29:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [29:0] out_pc;
  int tests = 0;
  int fails = 0;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hA0A0A0A0;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) imem_inst <= '0;
    else imem_inst <= rom(imem_pc);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Model: decode must see an unbroken, in-order pc stream restarting at each
  // redirect target, with fixed restart latency and full streaming throughput.
  logic [29:0] exp_pc = RESET_PC;
  int  gap = 2;
  bit  due = 1'b0;
  bit  prev_flow = 1'b0;
  bit  prev_hold = 1'b0;
  int  run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_inst", out_inst, 0);
      chk("rst_imem_pc", imem_pc, RESET_PC);
      exp_pc = RESET_PC; gap = 2; due = 0; prev_flow = 0; prev_hold = 0; run = 0;
    end else begin
      if (gap > 0) begin
        chk("restart_quiet", out_valid, 0);
        gap--;
        due = gap == 0;
      end else if (due) begin
        chk("restart_first", out_valid, 1);
        due = 0;
      end
      if (prev_flow) chk("throughput", out_valid, 1);
      if (prev_hold) chk("hold_valid", out_valid, 1);
      if (out_valid) begin
        chk("order_pc", out_pc, exp_pc);
        chk("order_inst", out_inst, rom(exp_pc));
      end
      if (run >= 2 && out_valid) chk("stall_fpc", imem_pc, 30'(exp_pc + 30'd2));
      prev_flow = out_valid && out_ready && !redirect_valid;
      prev_hold = out_valid && !out_ready && !redirect_valid;
      run = prev_hold ? run + 1 : 0;
      if (out_valid && out_ready) exp_pc = exp_pc + 30'd1;
      if (redirect_valid) begin
        exp_pc = redirect_pc; gap = 2; due = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("lit_first_valid", out_valid, 1);
    chk("lit_first_pc", out_pc, 30'h0);
    chk("lit_first_inst", out_inst, 32'hA0A0A0A3);
    cyc(3);
    chk("lit_pc3", out_pc, 30'h3);
    chk("lit_inst3", out_inst, 32'hA0A0A0AF);
    cyc(1);
    out_ready = 1'b0;
    cyc(4);
    chk("lit_stall_pc", out_pc, 30'h4);
    chk("lit_stall_inst", out_inst, 32'hA0A0A0B3);
    chk("lit_stall_imem", imem_pc, 30'h6);
    cyc(1);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 30'h10;
    cyc(1);
    redirect_valid = 1'b0;
    chk("lit_redir_gap", out_valid, 0);
    cyc(2);
    chk("lit_redir_valid", out_valid, 1);
    chk("lit_redir_pc", out_pc, 30'h10);
    cyc(4);
    redirect_valid = 1'b1;
    redirect_pc = 30'h20;
    cyc(1);
    redirect_pc = 30'h30;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(2);
    chk("lit_b2b_pc", out_pc, 30'h30);
    cyc(3);
    redirect_valid = 1'b1;
    redirect_pc = 30'h3FFFFFFE;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(2);
    chk("lit_wrap_top", out_pc, 30'h3FFFFFFE);
    cyc(2);
    chk("lit_wrap_zero", out_pc, 30'h0);
    cyc(3);
    for (int i = 0; i < 300; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_pc = 30'($urandom);
      cyc(1);
    end
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    cyc(5);
    chk("lit_full_before_rst", out_valid, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("lit_async_rst_valid", out_valid, 0);
    cyc(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(2);
    chk("lit_after_rst_valid", out_valid, 1);
    chk("lit_after_rst_pc", out_pc, RESET_PC);
    cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
